// File: rtl/gated_reg_wr_arbiter.sv
// Round-robin write arbiter for a bank of clock-gated registers.
// Drives registered one-hot gate enables and a shared write-data bus.
module gated_reg_wr_arbiter #(
   parameter int NumReq    = 4,
   parameter int NumRegs   = 8,
   parameter int DataWidth = 8,
   parameter int MaxLock   = 4,
   localparam int AddrWidth = $clog2(NumRegs)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumReq-1:0]             req_valid_i,
   input  logic [NumReq-1:0]             req_lock_i,
   input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
   input  logic [NumReq*DataWidth-1:0]   req_data_i,
   output logic [NumReq-1:0]             req_ready_o,
   output logic [NumRegs-1:0]            gate_en_o,
   output logic [DataWidth-1:0]          wdata_o,
   output logic                          addr_err_o,
   output logic                          busy_o
);

   localparam int ReqW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int CntW = $clog2(MaxLock + 1);
   localparam logic [ReqW:0]      NumReqW  = NumReq[ReqW:0];
   localparam logic [ReqW-1:0]    LastReq  = ReqW'(NumReq - 1);
   localparam logic [AddrWidth:0] NumRegsW = NumRegs[AddrWidth:0];
   localparam logic [CntW-1:0]    MaxLockW = CntW'(MaxLock);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e                state_q, state_d;
   logic [ReqW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [ReqW-1:0]       owner_q, owner_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [NumRegs-1:0]    gate_en_q, gate_en_d;
   logic [DataWidth-1:0]  wdata_q, wdata_d;
   logic                  err_q, err_d;

   logic [NumReq-1:0]     ready;
   logic [ReqW-1:0]       gnt_idx;
   logic [ReqW:0]         idx;
   logic                  found, hs, gnt_lock;
   logic [AddrWidth-1:0]  gnt_addr;
   logic [DataWidth-1:0]  gnt_data;

   function automatic logic [ReqW-1:0] inc(input logic [ReqW-1:0] v);
      return (v == LastReq) ? '0 : v + 1'b1;
   endfunction

   // Grant selection: owner only while locked, else first valid from rr_ptr.
   always_comb begin
      ready   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      if (state_q == LOCKED) begin
         if (req_valid_i[owner_q]) begin
            found   = 1'b1;
            gnt_idx = owner_q;
         end
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            idx = {1'b0, rr_ptr_q} + (ReqW+1)'(i);
            if (idx >= NumReqW) idx = idx - NumReqW;
            if (!found && req_valid_i[idx[ReqW-1:0]]) begin
               found   = 1'b1;
               gnt_idx = idx[ReqW-1:0];
            end
         end
      end
      hs = found && !rst_i;
      if (hs) ready[gnt_idx] = 1'b1;
   end

   assign gnt_addr = req_addr_i[gnt_idx*AddrWidth +: AddrWidth];
   assign gnt_data = req_data_i[gnt_idx*DataWidth +: DataWidth];
   assign gnt_lock = req_lock_i[gnt_idx];

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      rr_ptr_d  = rr_ptr_q;
      gate_en_d = '0;
      wdata_d   = wdata_q;
      err_d     = 1'b0;
      if (hs) begin
         wdata_d  = gnt_data;
         rr_ptr_d = inc(gnt_idx);
         if ({1'b0, gnt_addr} < NumRegsW) gate_en_d[gnt_addr] = 1'b1;
         else err_d = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (hs && gnt_lock && (MaxLock > 1)) begin
               state_d = LOCKED;
               owner_d = gnt_idx;
               cnt_d   = CntW'(1);
            end
         end
         LOCKED: begin
            if (!hs) begin
               state_d  = IDLE;
               cnt_d    = '0;
               rr_ptr_d = inc(owner_q);
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (!gnt_lock || cnt_d == MaxLockW) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         cnt_q     <= '0;
         rr_ptr_q  <= '0;
         gate_en_q <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         rr_ptr_q  <= rr_ptr_d;
         gate_en_q <= gate_en_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
      end
   end

   assign req_ready_o = ready;
   assign gate_en_o   = gate_en_q;
   assign wdata_o     = wdata_q;
   assign addr_err_o  = err_q;
   assign busy_o      = (state_q == LOCKED);

endmodule
